game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_pkg.sv | 30 +++
 rtl/game_sequencer_if.sv | 37 +++
 rtl/game_sequencer_frame_timer.sv | 44 ++++
 rtl/game_sequencer.sv | 164 ++++++++++++++++
 tb/tb_game_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared state encodings, parameter defaults and helpers
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RUNNING     = 3'd1,
        ST_DYING       = 3'd2,
        ST_LEVEL_PAUSE = 3'd3,
        ST_GAME_OVER   = 3'd4
    } state_e;

    localparam int LIVES_INI_DEF    = 3;
    localparam int DEATH_FRAMES_DEF = 60;
    localparam int LEVEL_FRAMES_DEF = 30;
    localparam int FLASH_FRAMES_DEF = 8;

    localparam int CNT_W   = 8;
    localparam int LIVES_W = 3;

    // States in which a fresh press of start is required before leaving.
    function automatic logic is_armable(state_e s);
        return (s == ST_IDLE) || (s == ST_GAME_OVER);
    endfunction

    // States in which the display blink runs.
    function automatic logic is_flashing(state_e s);
        return (s == ST_DYING) || (s == ST_GAME_OVER);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - control/status bundle between game logic and the sequencer
//   i_Frame_Tick   : one-cycle pulse per video frame
//   i_Start        : debounced all-switches-pressed level
//   i_Has_Collided : frog/car collision level
//   i_Level_Up     : one-cycle pulse when the frog reaches the goal
//   o_Game_Active  : frog may move
//   o_Cars_Enable  : obstacle movement enable
//   o_Frog_Respawn : one-cycle pulse returning the frog to base
//   o_Lives        : remaining lives
//   o_Game_Over    : high while in GAME_OVER
//   o_Flash        : display blink enable
//   o_State        : current state encoding (debug)
interface game_sequencer_if;
    logic       i_Frame_Tick;
    logic       i_Start;
    logic       i_Has_Collided;
    logic       i_Level_Up;
    logic       o_Game_Active;
    logic       o_Cars_Enable;
    logic       o_Frog_Respawn;
    logic [2:0] o_Lives;
    logic       o_Game_Over;
    logic       o_Flash;
    logic [2:0] o_State;

    modport master (
        output i_Frame_Tick, i_Start, i_Has_Collided, i_Level_Up,
        input  o_Game_Active, o_Cars_Enable, o_Frog_Respawn, o_Lives,
               o_Game_Over, o_Flash, o_State
    );

    modport slave (
        input  i_Frame_Tick, i_Start, i_Has_Collided, i_Level_Up,
        output o_Game_Active, o_Cars_Enable, o_Frog_Respawn, o_Lives,
               o_Game_Over, o_Flash, o_State
    );
endinterface

// File: rtl/game_sequencer_frame_timer.sv
// rtl/game_sequencer_frame_timer.sv - tick-driven 8-bit terminal-count down-counter
//   i_Clk, i_Reset : clock, synchronous active-high reset
//   i_Load         : load i_Load_Val this cycle (wins over a tick)
//   i_Load_Val     : reload value (1..255)
//   i_Tick         : frame tick; the count only moves on a tick
//   o_Expire       : combinational, high on the tick that completes the count
module frame_timer
    import game_sequencer_pkg::*;
(
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Load,
    input  logic [CNT_W-1:0] i_Load_Val,
    input  logic             i_Tick,
    output logic             o_Expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Holds at zero rather than wrapping, so a timer left running in an
    // idle state never produces spurious expiries.
    always_comb begin
        count_d = count_q;
        if (i_Load) begin
            count_d = i_Load_Val;
        end else if (i_Tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Expiry is flagged on the tick that would take the count from 1 to 0,
    // so the owner can change state on the same edge that samples it.
    assign o_Expire = i_Tick && (count_q == CNT_W'(1));

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - frogger-style game flow FSM with lives, pauses and blink
//   i_Clk   : single clock, rising edge
//   i_Reset : synchronous active-high reset, overrides every other input
//   bus     : game_sequencer_if.slave carrying the frame/start/collision/level
//             inputs and the registered status outputs
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int C_LIVES_INI    = LIVES_INI_DEF,
    parameter int C_DEATH_FRAMES = DEATH_FRAMES_DEF,
    parameter int C_LEVEL_FRAMES = LEVEL_FRAMES_DEF,
    parameter int C_FLASH_FRAMES = FLASH_FRAMES_DEF
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    game_sequencer_if.slave   bus
);

    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               armed_q, armed_d;
    logic               flash_q, flash_d;
    logic               respawn_q, respawn_d;
    logic               game_active_q, game_active_d;
    logic               cars_q, cars_d;
    logic               game_over_q, game_over_d;

    logic               entering;
    logic               pause_load;
    logic [CNT_W-1:0]   pause_val;
    logic               pause_expire;
    logic               flash_load;
    logic               flash_expire;

    frame_timer u_pause_timer (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Load     (pause_load),
        .i_Load_Val (pause_val),
        .i_Tick     (bus.i_Frame_Tick),
        .o_Expire   (pause_expire)
    );

    frame_timer u_flash_timer (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Load     (flash_load),
        .i_Load_Val (CNT_W'(C_FLASH_FRAMES)),
        .i_Tick     (bus.i_Frame_Tick),
        .o_Expire   (flash_expire)
    );

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        pause_load = 1'b0;
        pause_val  = CNT_W'(C_DEATH_FRAMES);

        case (state_q)
            ST_IDLE: begin
                if (armed_q && bus.i_Start) begin
                    state_d = ST_RUNNING;
                    lives_d = LIVES_W'(C_LIVES_INI);
                end
            end
            ST_RUNNING: begin
                // Collision is checked first so it wins over a same-cycle level-up.
                if (bus.i_Has_Collided) begin
                    state_d    = ST_DYING;
                    lives_d    = (lives_q == '0) ? '0 : lives_q - 1'b1;
                    pause_load = 1'b1;
                    pause_val  = CNT_W'(C_DEATH_FRAMES);
                end else if (bus.i_Level_Up) begin
                    state_d    = ST_LEVEL_PAUSE;
                    pause_load = 1'b1;
                    pause_val  = CNT_W'(C_LEVEL_FRAMES);
                end
            end
            ST_DYING: begin
                if (pause_expire) begin
                    state_d = (lives_q == '0) ? ST_GAME_OVER : ST_RUNNING;
                end
            end
            ST_LEVEL_PAUSE: begin
                if (pause_expire) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_GAME_OVER: begin
                if (armed_q && bus.i_Start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        entering = (state_d != state_q);

        // Start must be seen released inside IDLE/GAME_OVER before a press
        // counts, so a button still held from the last transition is ignored.
        armed_d = armed_q;
        if (is_armable(state_q) && !bus.i_Start) begin
            armed_d = 1'b1;
        end
        if (entering && is_armable(state_d)) begin
            armed_d = 1'b0;
        end

        respawn_d = entering && (state_d == ST_RUNNING);

        // Blink phase restarts low on every entry to a flashing state,
        // including the DYING -> GAME_OVER hand-over.
        flash_load = 1'b0;
        flash_d    = flash_q;
        if (entering && is_flashing(state_d)) begin
            flash_load = 1'b1;
            flash_d    = 1'b0;
        end else if (is_flashing(state_d)) begin
            if (flash_expire) begin
                flash_load = 1'b1;
                flash_d    = ~flash_q;
            end
        end else begin
            flash_d = 1'b0;
        end

        game_active_d = (state_d == ST_RUNNING);
        cars_d        = (state_d == ST_RUNNING) || (state_d == ST_LEVEL_PAUSE);
        game_over_d   = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            lives_q       <= LIVES_W'(C_LIVES_INI);
            armed_q       <= 1'b0;
            flash_q       <= 1'b0;
            respawn_q     <= 1'b0;
            game_active_q <= 1'b0;
            cars_q        <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            armed_q       <= armed_d;
            flash_q       <= flash_d;
            respawn_q     <= respawn_d;
            game_active_q <= game_active_d;
            cars_q        <= cars_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.o_Game_Active  = game_active_q;
    assign bus.o_Cars_Enable  = cars_q;
    assign bus.o_Frog_Respawn = respawn_q;
    assign bus.o_Lives        = lives_q;
    assign bus.o_Game_Over    = game_over_q;
    assign bus.o_Flash        = flash_q;
    assign bus.o_State        = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
module tb_game_sequencer;

    localparam int LI = 2;
    localparam int DF = 4;
    localparam int LF = 2;
    localparam int FF = 3;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DIE  = 2;
    localparam int M_LVL  = 3;
    localparam int M_OVER = 4;

    logic clk;
    logic rst;

    game_sequencer_if bus ();

    game_sequencer #(
        .C_LIVES_INI    (LI),
        .C_DEATH_FRAMES (DF),
        .C_LEVEL_FRAMES (LF),
        .C_FLASH_FRAMES (FF)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: counts frames upward and reasons in terms of the
    // game rules (modes, lives, armed, elapsed ticks).
    int  m_mode, m_lives, m_ticks, m_fticks;
    bit  m_armed, m_flash, m_respawn, m_valid;

    function automatic bit armable(int m);
        return (m == M_IDLE) || (m == M_OVER);
    endfunction

    function automatic bit blinking(int m);
        return (m == M_DIE) || (m == M_OVER);
    endfunction

    always @(posedge clk) begin
        int nxt;
        if (rst) begin
            m_mode = M_IDLE; m_lives = LI; m_ticks = 0; m_fticks = 0;
            m_armed = 0; m_flash = 0; m_respawn = 0; m_valid = 1;
        end else if (m_valid) begin
            nxt = m_mode;
            m_respawn = 0;
            case (m_mode)
                M_IDLE: if (m_armed && bus.i_Start) begin
                    nxt = M_RUN; m_lives = LI; m_respawn = 1;
                end
                M_RUN: if (bus.i_Has_Collided) begin
                    nxt = M_DIE; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_ticks = 0;
                end else if (bus.i_Level_Up) begin
                    nxt = M_LVL; m_ticks = 0;
                end
                M_DIE: if (bus.i_Frame_Tick) begin
                    m_ticks++;
                    if (m_ticks == DF) begin
                        if (m_lives == 0) nxt = M_OVER;
                        else begin nxt = M_RUN; m_respawn = 1; end
                    end
                end
                M_LVL: if (bus.i_Frame_Tick) begin
                    m_ticks++;
                    if (m_ticks == LF) begin nxt = M_RUN; m_respawn = 1; end
                end
                M_OVER: if (m_armed && bus.i_Start) nxt = M_IDLE;
                default: nxt = M_IDLE;
            endcase
            if (nxt != m_mode && armable(nxt)) m_armed = 0;
            else if (armable(m_mode) && !bus.i_Start) m_armed = 1;
            if (nxt != m_mode && blinking(nxt)) begin
                m_flash = 0; m_fticks = 0;
            end else if (blinking(nxt)) begin
                if (bus.i_Frame_Tick) begin
                    m_fticks++;
                    if (m_fticks == FF) begin m_flash = !m_flash; m_fticks = 0; end
                end
            end else begin
                m_flash = 0;
            end
            m_mode = nxt;
        end
    end

    // Compare process: whole output bundle against the model every cycle.
    always @(negedge clk) begin
        logic [10:0] exp_v, act_v;
        if (m_valid) begin
            exp_v = {3'(m_mode), 3'(m_lives), m_mode == M_RUN,
                     (m_mode == M_RUN) || (m_mode == M_LVL), m_respawn,
                     m_mode == M_OVER, m_flash};
            act_v = {bus.o_State, bus.o_Lives, bus.o_Game_Active, bus.o_Cars_Enable,
                     bus.o_Frog_Respawn, bus.o_Game_Over, bus.o_Flash};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL outputs t=%0t got state=%0d lives=%0d ga/ce/rs/go/fl=%b need state=%0d lives=%0d ga/ce/rs/go/fl=%b",
                         $time, act_v[10:8], act_v[7:5], act_v[4:0],
                         exp_v[10:8], exp_v[7:5], exp_v[4:0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d need %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse(input int gap);
        bus.i_Frame_Tick = 1'b1;
        step(1);
        bus.i_Frame_Tick = 1'b0;
        if (gap > 0) step(gap);
    endtask

    function automatic int flags();
        return {bus.o_Game_Active, bus.o_Cars_Enable, bus.o_Frog_Respawn,
                bus.o_Game_Over, bus.o_Flash};
    endfunction

    initial begin
        m_valid = 0;
        rst = 1'b1;
        bus.i_Frame_Tick = 0; bus.i_Start = 1; bus.i_Has_Collided = 0; bus.i_Level_Up = 0;
        step(2);
        chk("rst_state", bus.o_State, M_IDLE);
        chk("rst_lives", bus.o_Lives, LI);
        chk("rst_flags", flags(), 0);

        // Scenario 1: held start is ignored until released and pressed again.
        rst = 1'b0;
        step(5);
        chk("s1_hold_idle", bus.o_State, M_IDLE);
        bus.i_Start = 0; step(1);
        bus.i_Start = 1; step(1);
        chk("s1_state", bus.o_State, M_RUN);
        chk("s1_lives", bus.o_Lives, 2);
        chk("s1_respawn", bus.o_Frog_Respawn, 1);
        step(1);
        chk("s1_respawn_once", bus.o_Frog_Respawn, 0);

        // Scenario 2: first collision, death pause, back to running.
        bus.i_Has_Collided = 1; step(1); bus.i_Has_Collided = 0;
        chk("s2_state", bus.o_State, M_DIE);
        chk("s2_lives", bus.o_Lives, 1);
        chk("s2_cars", bus.o_Cars_Enable, 0);
        for (int i = 0; i < DF - 1; i++) tick_pulse(2);
        chk("s2_still_dying", bus.o_State, M_DIE);
        tick_pulse(0);
        chk("s2_back_run", bus.o_State, M_RUN);
        chk("s2_respawn", bus.o_Frog_Respawn, 1);
        step(1);

        // Scenario 3: last life lost, game over with blinking.
        bus.i_Has_Collided = 1; step(1); bus.i_Has_Collided = 0;
        chk("s3_lives", bus.o_Lives, 0);
        for (int i = 0; i < DF; i++) tick_pulse(2);
        chk("s3_state", bus.o_State, M_OVER);
        chk("s3_game_over", bus.o_Game_Over, 1);
        chk("s3_flash0", bus.o_Flash, 0);
        for (int i = 0; i < FF; i++) tick_pulse(2);
        chk("s3_flash1", bus.o_Flash, 1);
        for (int i = 0; i < FF; i++) tick_pulse(2);
        chk("s3_flash2", bus.o_Flash, 0);
        bus.i_Start = 0; step(1);
        bus.i_Start = 1; step(1);
        chk("s3_to_idle", bus.o_State, M_IDLE);

        // Scenario 4: collision beats level-up; level pause lasts LF ticks.
        bus.i_Start = 0; step(1);
        bus.i_Start = 1; step(1);
        chk("s4_run", bus.o_State, M_RUN);
        bus.i_Has_Collided = 1; bus.i_Level_Up = 1; step(1);
        bus.i_Has_Collided = 0; bus.i_Level_Up = 0;
        chk("s4_collide_wins", bus.o_State, M_DIE);
        for (int i = 0; i < DF; i++) tick_pulse(2);
        step(1);
        bus.i_Level_Up = 1; step(1); bus.i_Level_Up = 0;
        chk("s4_level", bus.o_State, M_LVL);
        chk("s4_cars", bus.o_Cars_Enable, 1);
        tick_pulse(2);
        chk("s4_level_hold", bus.o_State, M_LVL);
        tick_pulse(0);
        chk("s4_level_done", bus.o_State, M_RUN);
        step(1);

        // Scenario 5: reset in the middle of a death pause.
        bus.i_Has_Collided = 1; step(1); bus.i_Has_Collided = 0;
        tick_pulse(2); tick_pulse(2);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("s5_state", bus.o_State, M_IDLE);
        chk("s5_lives", bus.o_Lives, LI);
        chk("s5_flags", flags(), 0);
        bus.i_Start = 0; step(1);
        bus.i_Start = 1; step(1);
        bus.i_Has_Collided = 1; step(1); bus.i_Has_Collided = 0;
        for (int i = 0; i < DF - 1; i++) tick_pulse(2);
        chk("s5_full_pause", bus.o_State, M_DIE);
        tick_pulse(0);
        chk("s5_restart_clean", bus.o_State, M_RUN);

        // Randomized play checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) bus.i_Start = ~bus.i_Start;
            bus.i_Has_Collided = ($urandom_range(0, 24) == 0);
            bus.i_Level_Up     = ($urandom_range(0, 19) == 0);
            bus.i_Frame_Tick   = ($urandom_range(0, 2) == 0);
            step(1);
        end
        rst = 0;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
